// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and reset-ratio helper for the clock divider bank
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Reset divisor code for channel i: reproduces the legacy div2/4/8/16 chain.
    function automatic int unsigned default_div(input int unsigned i);
        return (32'd1 << i) - 32'd1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one programmable divider channel with shadowed reconfiguration
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W = 8,
    parameter logic [CNT_W-1:0] RST_D = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [CNT_W-1:0] cfg_div,
    input  mode_e            cfg_mode,
    output logic             div_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_d;
    logic [CNT_W-1:0] shd_d;
    mode_e            act_mode;
    mode_e            shd_mode;
    logic             tc;

    // Terminal count only exists while counting is enabled.
    assign tc = en && (cnt == act_d);

    // Counter, shadow apply and output generation; the config write is evaluated
    // last so a colliding write always lands in the shadow after any apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            act_d    <= RST_D;
            shd_d    <= RST_D;
            act_mode <= MODE_TOGGLE;
            shd_mode <= MODE_TOGGLE;
            pending  <= 1'b0;
            div_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (sync) begin
                cnt     <= '0;
                div_out <= 1'b0;
                tick    <= 1'b0;
                if (pending) begin
                    act_d    <= shd_d;
                    act_mode <= shd_mode;
                    pending  <= 1'b0;
                end
            end else if (en) begin
                tick <= tc;
                if (tc) begin
                    cnt <= '0;
                    if (pending) begin
                        // New ratio/mode always starts from a low output.
                        act_d    <= shd_d;
                        act_mode <= shd_mode;
                        pending  <= 1'b0;
                        div_out  <= 1'b0;
                    end else if (act_mode == MODE_TOGGLE) begin
                        div_out <= ~div_out;
                    end else begin
                        div_out <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    if (act_mode == MODE_PULSE) begin
                        div_out <= 1'b0;
                    end
                end
            end else begin
                tick <= 1'b0;
            end

            if (we) begin
                shd_d    <= cfg_div;
                shd_mode <= cfg_mode;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of independent programmable clock divider channels
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    input  logic                                  sync,
    input  logic                                  cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                      cfg_div,
    input  logic                                  cfg_mode,
    output logic [N_CH-1:0]                       div_out,
    output logic [N_CH-1:0]                       tick,
    output logic [N_CH-1:0]                       pending
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] ch_we;

    // Decode the channel select; codes beyond the last channel match nothing.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                ch_we[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W (CNT_W),
            .RST_D (CNT_W'(default_div(i)))
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .sync     (sync),
            .we       (ch_we[i]),
            .cfg_div  (cfg_div),
            .cfg_mode (mode_e'(cfg_mode)),
            .div_out  (div_out[i]),
            .tick     (tick[i]),
            .pending  (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed vector bench for clk_div_bank
module tb_clk_div_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_mode = 1'b0;
    logic [3:0] div_out;
    logic [3:0] tick;
    logic [3:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         rst;
        logic       en;
        logic       sync;
        logic       we;
        logic [1:0] ch;
        logic [7:0] d;
        logic       mode;
        logic [3:0] mask;
        logic [3:0] e_div;
        logic [3:0] e_tick;
        logic [3:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    clk_div_bank #(.N_CH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .div_out  (div_out),
        .tick     (tick),
        .pending  (pending)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input bit rst, input logic e, input logic s, input logic w,
                                input logic [1:0] c, input logic [7:0] d, input logic m,
                                input logic [3:0] mask, input logic [3:0] ed,
                                input logic [3:0] et, input logic [3:0] ep);
        vec_t v;
        v.rst = rst; v.en = e; v.sync = s; v.we = w; v.ch = c; v.d = d; v.mode = m;
        v.mask = mask; v.e_div = ed; v.e_tick = et; v.e_pend = ep;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        en     = 1'b0;
        sync   = 1'b0;
        cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset div_out", div_out, 4'b0000);
        check("reset tick", tick, 4'b0000);
        check("reset pending", pending, 4'b0000);
        rst_n = 1'b1;
    endtask

    initial begin
        // Defaults: legacy div2/4/8/16 chain, outputs count in binary.
        add(1,1,0,0,0,0,0, 4'hF, 4'b0001, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0010, 4'b0011, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0011, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0100, 4'b0111, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0101, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0110, 4'b0011, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0111, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b1000, 4'b1111, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b1001, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b1010, 4'b0011, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b1011, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b1100, 4'b0111, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b1101, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b1110, 4'b0011, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b1111, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0000, 4'b1111, 4'b0000);
        // ch0 -> D=2 toggle: applied at next TC, then 3 high / 3 low.
        add(1,1,0,1,0,2,0, 4'h1, 4'b0001, 4'b0001, 4'b0001);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0000, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0000, 4'b0000, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0000, 4'b0000, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0001, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0001, 4'b0000, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0001, 4'b0000, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0000, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0000, 4'b0000, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0000, 4'b0000, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0001, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h1, 4'b0001, 4'b0000, 4'b0000);
        // ch1 -> D=4 pulse: single-cycle pulse every 5 cycles.
        add(1,1,0,1,1,4,1, 4'h2, 4'b0000, 4'b0000, 4'b0010);
        add(0,1,0,0,0,0,0, 4'h2, 4'b0000, 4'b0010, 4'b0000);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) add(0,1,0,0,0,0,0, 4'h2, 4'b0000, 4'b0000, 4'b0000);
            add(0,1,0,0,0,0,0, 4'h2, 4'b0010, 4'b0010, 4'b0000);
        end
        // en low for 7 cycles, with a write to ch3 accepted while frozen.
        add(1,1,0,0,0,0,0, 4'hF, 4'b0001, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0010, 4'b0011, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0011, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0100, 4'b0111, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0101, 4'b0001, 4'b0000);
        add(0,0,0,1,3,7,0, 4'hF, 4'b0101, 4'b0000, 4'b1000);
        for (int k = 0; k < 6; k++) add(0,0,0,0,0,0,0, 4'hF, 4'b0101, 4'b0000, 4'b1000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0110, 4'b0011, 4'b1000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0111, 4'b0001, 4'b1000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0000, 4'b1111, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0001, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0010, 4'b0011, 4'b0000);
        // sync while ch2 holds a pending D=1: all restart in phase, ch2 on new ratio.
        add(1,1,0,1,2,1,0, 4'hF, 4'b0001, 4'b0001, 4'b0100);
        add(0,1,1,0,0,0,0, 4'hF, 4'b0000, 4'b0000, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0001, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0110, 4'b0111, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0111, 4'b0001, 4'b0000);
        add(0,1,0,0,0,0,0, 4'hF, 4'b0000, 4'b0111, 4'b0000);
        // Write on the TC cycle with pending=1: old shadow applied, new one waits.
        add(1,1,0,1,1,2,0, 4'h2, 4'b0000, 4'b0000, 4'b0010);
        add(0,1,0,1,1,0,0, 4'h2, 4'b0000, 4'b0010, 4'b0010);
        add(0,1,0,0,0,0,0, 4'h2, 4'b0000, 4'b0000, 4'b0010);
        add(0,1,0,0,0,0,0, 4'h2, 4'b0000, 4'b0000, 4'b0010);
        add(0,1,0,0,0,0,0, 4'h2, 4'b0000, 4'b0010, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h2, 4'b0010, 4'b0010, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h2, 4'b0000, 4'b0010, 4'b0000);
        add(0,1,0,0,0,0,0, 4'h2, 4'b0010, 4'b0010, 4'b0000);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            en       = vecs[k].en;
            sync     = vecs[k].sync;
            cfg_we   = vecs[k].we;
            cfg_ch   = vecs[k].ch;
            cfg_div  = vecs[k].d;
            cfg_mode = vecs[k].mode;
            @(posedge clk);
            #1;
            check($sformatf("vec %0d div_out", k), div_out & vecs[k].mask, vecs[k].e_div);
            check($sformatf("vec %0d tick", k), tick & vecs[k].mask, vecs[k].e_tick);
            check($sformatf("vec %0d pending", k), pending, vecs[k].e_pend);
        end

        // Asynchronous reset mid-run clears a pending write and restores defaults.
        do_reset();
        en       = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 2'd2;
        cfg_div  = 8'd5;
        cfg_mode = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset div_out", div_out, 4'b0011);
        check("pre-reset pending", pending, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset div_out", div_out, 4'b0000);
        check("async reset tick", tick, 4'b0000);
        check("async reset pending", pending, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset edge %0d div_out", i), div_out, 4'(i));
        end
        check("post-reset pending", pending, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of N_CH independent programmable clock dividers, the successor to the fixed div2/div4/div8/div16 chain in the top-level wrapper. Each channel divides `clk` by a runtime-programmable ratio in either 50%-duty toggle mode or single-cycle pulse mode. Reprogramming is glitch-free via per-channel shadow registers, and a global sync input phase-aligns all channels. Out of reset, the bank reproduces the legacy div2/4/8/16 outputs on channels 0..3.

## Interface
- N_CH, 4: number of divider channels (1..16).
- CNT_W, 8: counter/divisor width; requires CNT_W >= N_CH-1.
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global count enable; low freezes all channels.
- sync  in  1  single-cycle pulse; restarts all channels in phase.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel; values >= N_CH are ignored.
- cfg_div  in  CNT_W  divisor code D.
- cfg_mode  in  1  0 = toggle, 1 = pulse.
- div_out  out  N_CH  divided outputs, registered.
- tick  out  N_CH  terminal-count pulses, registered.
- pending  out  N_CH  shadow holds an unapplied write.

## Operation
- Per channel state: cnt[CNT_W], active D and mode, shadow D and mode, pending, div_out, tick.
- Terminal count (TC): the cycle in which en=1 and cnt == active D.
- Counting: with en=1, cnt increments each cycle. At TC, cnt wraps to 0.
- Toggle mode:
  - div_out inverts at each TC, giving a period of 2(D+1) cycles at 50% duty.
  - D=0 gives div2.
- Pulse mode:
  - div_out equals tick.
  - Period is D+1 cycles.
  - D=0 holds div_out high continuously.
- tick is 1 in the cycle after each TC in both modes, otherwise 0.
- Config write (cfg_we=1, cfg_ch valid):
  - Shadow D and mode <= cfg_div and cfg_mode; pending <= 1.
  - A later write before apply overwrites the shadow.
- Apply at TC while pending:
  - Active D and mode <= shadow; pending <= 0.
  - div_out <= 0, so a new mode or ratio always starts from low.
- Write collides with TC on the same channel:
  - The old shadow is applied.
  - The new write is latched into the shadow; pending stays 1.
- Write collides with TC while pending=0: the write is latched and waits for the next TC.
- sync=1 (priority over en and TC):
  - All cnt <= 0, div_out <= 0, tick <= 0.
  - Every pending shadow is applied and pending is cleared.
  - A cfg write in the same cycle is latched after the apply, leaving pending=1.
- en=0: cnt, div_out and pending hold; tick forced 0. Config writes are still accepted.
- Reset values:
  - cnt = 0, div_out = 0, tick = 0, pending = 0.
  - Channel i: active and shadow D = 2^i − 1, mode = toggle. This yields div2, div4, div8, div16.
- Arithmetic: cnt compare is an unsigned equality on CNT_W bits; no overflow is possible because cnt never exceeds D.

## Timing
- Latency: all outputs are registered; no combinational path from inputs to outputs.
- After rst_n deassertion with en=1, channel 0's div_out first rises at edge 1 (div2 starting in phase).
- A write takes effect at the first TC strictly after the write cycle. The worst-case wait is one old period (D_old+1 cycles); the new ratio's first full period follows.
- sync takes effect at the next edge. All channels then count from 0 in lock-step.
- rst_n assertion mid-operation clears state immediately (asynchronous), including pending writes.

## Structure
- Package clk_div_pkg:
  - mode_e enum: MODE_TOGGLE=0, MODE_PULSE=1.
  - Function default_div(i) returning 2^i − 1.
- Sub-module clk_div_chan: one channel (counter, shadow, apply logic, outputs). It has port `sync` and a decoded per-channel write strobe.
- clk_div_bank:
  - Decodes cfg_ch into per-channel strobes.
  - Instantiates N_CH clk_div_chan in a generate loop.

## Test plan
- Reset, en=1, defaults → div_out[0..3] periods 2/4/8/16 cycles at 50% duty; tick[3] every 8 cycles; pending=0.
- Write ch0 D=2 toggle mid-period → pending[0]=1 until the next TC. div_out[0] then starts low with period 6, high for 3 cycles; pending[0]=0.
- Write ch1 D=4 pulse, then run 20 cycles → div_out[1] and tick[1] high for 1 cycle every 5 cycles.
- en low for 7 cycles mid-count → all div_out frozen, tick=0; on resume, count continues from the frozen cnt with no extra or lost edges.
- After skewing channels via writes, pulse sync while ch2 has a pending write → all div_out=0 next cycle, channels in phase, ch2 running its new ratio with pending[2]=0.
- Write on the exact TC cycle with pending=1 → old shadow applied, new value applied at the following TC. rst_n pulsed low mid-run → immediate return to the reset values.
